// File: rtl/accel_feeder_if.sv
// Handshake and data bundle between accel_feeder, its operand producer,
// the accel datapath and the result consumer.
interface accel_feeder_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_a_i;
  logic [7:0]  in_b_i;
  logic        acc_start_o;
  logic [7:0]  acc_a_o;
  logic [7:0]  acc_b_o;
  logic        acc_busy_i;
  logic [15:0] acc_y_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_y_o;
  logic [15:0] done_cnt_o;
  logic        err_o;

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, acc_busy_i, acc_y_i, res_ready_i,
    output in_ready_o, acc_start_o, acc_a_o, acc_b_o, res_valid_o, res_y_o,
           done_cnt_o, err_o
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, acc_busy_i, acc_y_i, res_ready_i,
    input  in_ready_o, acc_start_o, acc_a_o, acc_b_o, res_valid_o, res_y_o,
           done_cnt_o, err_o
  );
endinterface

// File: rtl/accel_feeder.sv
// Operand FIFO, start/busy sequencer and result slot in front of the accel datapath.
// Define ACC_FEEDER_WDOG_EN to enable the WAIT_HI/WAIT_LO watchdog abort and err_o.
module accel_feeder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  accel_feeder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES == 0) begin : g_bad_cfg
    $error("accel_feeder: DEPTH must be a power of two >= 2 and WDOG_CYCLES > 0");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_nxt;

  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, capture, abort, timeout;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.in_valid_i && !full;
  assign bus.in_ready_o = !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.res_valid_o) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (timeout) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (bus.acc_busy_i) begin
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A busy fall on the timeout cycle still counts as a normal completion.
        if (!bus.acc_busy_i) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= bus.in_a_i;
      mem_b[wr_ptr[AW-1:0]] <= bus.in_b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.acc_start_o <= 1'b0;
      bus.acc_a_o     <= '0;
      bus.acc_b_o     <= '0;
      bus.res_valid_o <= 1'b0;
      bus.res_y_o     <= '0;
      bus.done_cnt_o  <= '0;
    end else begin
      state           <= state_nxt;
      bus.acc_start_o <= (state_nxt == ISSUE);
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + (AW + 1)'(1);
        bus.acc_a_o <= mem_a[rd_ptr[AW-1:0]];
        bus.acc_b_o <= mem_b[rd_ptr[AW-1:0]];
      end
      if (capture) begin
        bus.res_y_o     <= bus.acc_y_i;
        bus.res_valid_o <= 1'b1;
        bus.done_cnt_o  <= bus.done_cnt_o + 16'd1;
      end else if (abort) begin
        bus.res_y_o     <= '1;
        bus.res_valid_o <= 1'b1;
      end else if (bus.res_valid_o && bus.res_ready_i) begin
        bus.res_valid_o <= 1'b0;
      end
    end
  end

`ifdef ACC_FEEDER_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt;

  // Fires on the cycle whose increment would bring the count to WDOG_CYCLES.
  assign timeout = (wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_cnt  <= '0;
      bus.err_o <= 1'b0;
    end else begin
      if (state == ISSUE) wdog_cnt <= '0;
      else if (state == WAIT_HI || state == WAIT_LO) wdog_cnt <= wdog_cnt + WW'(1);
      if (abort) bus.err_o <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_accel_feeder.sv
// Randomized self-checking bench for accel_feeder with a behavioural accel stub
// and a queue-based reference model of the operand and result streams.
module tb_accel_feeder;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accel_feeder_if bus();

  accel_feeder #(.DEPTH(DEPTH), .WDOG_CYCLES(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {logic [7:0] a; logic [7:0] b;} op_t;

  op_t         op_q[$];
  logic [15:0] res_q[$];
  logic [15:0] acc_log[$];
  op_t         mon_op;
  int unsigned n_checks = 0, n_errors = 0, n_starts = 0, n_acc = 0;
  logic        mon_en = 1'b0, prev_start = 1'b0, dead = 1'b0, slow = 1'b0;
  logic [15:0] burst_exp [5] = '{16'd50, 16'd0, 16'd13, 16'd31, 16'd5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // y = 3*a + 2*cbrt(b), b a perfect cube in 0..216
  function automatic logic [15:0] ref_y(input logic [7:0] a, input logic [7:0] b);
    int unsigned r = 0;
    for (int unsigned k = 0; k <= 6; k++) if (k * k * k == int'(b)) r = k;
    return 16'(3 * int'(a) + 2 * r);
  endfunction

  // Accel stand-in: random start-to-busy latency and busy length, garbage y while busy.
  logic [1:0]  st_phase;
  int unsigned st_lat, st_len;
  logic [7:0]  st_a, st_b;
  always @(posedge clk) begin
    if (rst) begin
      bus.acc_busy_i <= 1'b0;
      bus.acc_y_i    <= '0;
      st_phase       <= 2'd0;
    end else begin
      case (st_phase)
        2'd0: if (bus.acc_start_o && !dead) begin
          st_a     <= bus.acc_a_o;
          st_b     <= bus.acc_b_o;
          st_lat   <= $urandom_range(0, 2);
          st_len   <= slow ? 30 : $urandom_range(1, 5);
          st_phase <= 2'd1;
        end
        2'd1: if (st_lat == 0) begin
          bus.acc_busy_i <= 1'b1;
          st_phase       <= 2'd2;
        end else st_lat <= st_lat - 1;
        default: if (st_len <= 1) begin
          bus.acc_busy_i <= 1'b0;
          bus.acc_y_i    <= ref_y(st_a, st_b);
          st_phase       <= 2'd0;
        end else begin
          st_len      <= st_len - 1;
          bus.acc_y_i <= 16'($urandom);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.acc_start_o) begin
        n_starts++;
        check("start_one_cycle", prev_start, 0);
        check("start_slot_free", bus.res_valid_o, 0);
        check("start_has_op", op_q.size() != 0, 1);
        if (op_q.size() != 0) begin
          mon_op = op_q.pop_front();
          check("acc_a", bus.acc_a_o, mon_op.a);
          check("acc_b", bus.acc_b_o, mon_op.b);
          res_q.push_back(ref_y(mon_op.a, mon_op.b));
        end
      end
      check("in_ready", bus.in_ready_o, op_q.size() < DEPTH);
      if (bus.in_valid_i && bus.in_ready_o) op_q.push_back('{bus.in_a_i, bus.in_b_i});
      if (bus.res_valid_o && bus.res_ready_i) begin
        check("res_pending", res_q.size() != 0, 1);
        if (res_q.size() != 0) check("res_y", bus.res_y_o, res_q.pop_front());
        check("done_cnt", bus.done_cnt_o, 16'(n_acc + 1));
        n_acc++;
        acc_log.push_back(bus.res_y_o);
      end
      prev_start = bus.acc_start_o;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid_i = 1'b1;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
    for (int unsigned i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) break;
    end
    if (!bus.in_ready_o) check("push_timeout", bus.in_ready_o, 1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_res(input int unsigned limit);
    for (int unsigned i = 0; i < limit && !bus.res_valid_o; i++) @(negedge clk);
    check("wait_res_valid", bus.res_valid_o, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_acc_start", bus.acc_start_o, 0);
    check("rst_acc_a", bus.acc_a_o, 0);
    check("rst_acc_b", bus.acc_b_o, 0);
    check("rst_res_valid", bus.res_valid_o, 0);
    check("rst_res_y", bus.res_y_o, 0);
    check("rst_done_cnt", bus.done_cnt_o, 0);
    check("rst_err", bus.err_o, 0);
  endtask

  task automatic drain(input int unsigned limit);
    bus.in_valid_i  = 1'b0;
    bus.res_ready_i = 1'b1;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (op_q.size() == 0 && res_q.size() == 0 && !bus.res_valid_o) break;
    end
    check("drain_empty", op_q.size() + res_q.size() + 32'(bus.res_valid_o), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned base, k;
    logic took;
    logic [15:0] base_done;
    bus.in_valid_i  = 1'b0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.res_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // single operation and push-to-issue latency
    push(8'd5, 8'd27);
    @(negedge clk);
    check("latency_n1_no_start", bus.acc_start_o, 0);
    @(negedge clk);
    check("latency_n2_start", bus.acc_start_o, 1);
    wait_res(60);
    check("single_y", bus.res_y_o, 21);
    check("single_done", bus.done_cnt_o, 1);
    check("single_starts", n_starts, 1);
    @(posedge clk); #1;
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;

    // burst under result backpressure
    acc_log.delete();
    base = n_starts;
    push(8'd14, 8'd64);
    push(8'd0, 8'd0);
    push(8'd3, 8'd8);
    push(8'd7, 8'd125);
    push(8'd1, 8'd1);
    @(negedge clk);
    check("burst_full", bus.in_ready_o, 0);
    repeat (30) @(negedge clk);
    check("burst_one_start", n_starts - base, 1);
    @(posedge clk); #1;
    bus.res_ready_i = 1'b1;
    for (int unsigned i = 0; i < 400 && acc_log.size() < 5; i++) @(negedge clk);
    check("burst_count", acc_log.size(), 5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++) check("burst_y", acc_log[i], burst_exp[i]);
    drain(200);

    // push coinciding with the IDLE pop at occupancy 2
    bus.res_ready_i = 1'b0;
    push(8'd2, 8'd1);
    wait_res(60);
    push(8'd4, 8'd8);
    push(8'd6, 8'd27);
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_a_i      = 8'd8;
    bus.in_b_i      = 8'd64;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("simul_pop_start", bus.acc_start_o, 1);
    check("simul_in_ready", bus.in_ready_o, 1);
    drain(300);

    // random traffic with random result backpressure
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      took = bus.in_valid_i && bus.in_ready_o;
      @(posedge clk); #1;
      if (!bus.in_valid_i || took) begin
        bus.in_valid_i = ($urandom_range(0, 2) != 0);
        bus.in_a_i     = 8'($urandom);
        k              = $urandom_range(0, 6);
        bus.in_b_i     = 8'(k * k * k);
      end
      bus.res_ready_i = ($urandom_range(0, 3) != 0);
    end
    drain(3000);

    // reset while waiting for busy to fall with 3 entries queued
    slow = 1'b1;
    push(8'd10, 8'd1);
    push(8'd11, 8'd8);
    push(8'd12, 8'd27);
    push(8'd13, 8'd64);
    for (int unsigned i = 0; i < 60 && !bus.acc_busy_i; i++) @(negedge clk);
    check("busy_rise", bus.acc_busy_i, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    op_q.delete();
    res_q.delete();
    n_acc      = 0;
    base       = n_starts;
    slow       = 1'b0;
    prev_start = 1'b0;
    mon_en     = 1'b1;
    repeat (40) @(negedge clk);
    check("stale_start", n_starts - base, 0);
    check("stale_res", bus.res_valid_o, 0);
    check("stale_done", bus.done_cnt_o, 0);
    @(posedge clk); #1;

    // accel never raises busy
    mon_en          = 1'b0;
    dead            = 1'b1;
    bus.res_ready_i = 1'b0;
    base_done       = bus.done_cnt_o;
    push(8'd9, 8'd8);
`ifdef ACC_FEEDER_WDOG_EN
    wait_res(60);
    check("wdog_y", bus.res_y_o, 16'hFFFF);
    check("wdog_err", bus.err_o, 1);
    check("wdog_done", bus.done_cnt_o, base_done);
`else
    repeat (100) @(negedge clk);
    check("stall_res_valid", bus.res_valid_o, 0);
    check("stall_err", bus.err_o, 0);
    check("stall_done", bus.done_cnt_o, base_done);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/accel_feeder.md
Name: accel_feeder

Overview:
- Upstream operand sequencer and result collector for the accel datapath, which computes y = 3*a + 2*cbrt(b).
- Buffers (a, b) operand pairs in a small FIFO using a valid/ready push interface.
- Issues one-cycle start pulses to accel and tracks its busy handshake.
- Captures each 16-bit result into a valid/ready output slot, so producers never see accel's busy protocol.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- WDOG_CYCLES, 64, watchdog limit in clocks; used only when ACC_FEEDER_WDOG_EN is defined.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous active-high reset.
- in_valid_i  input  1  operand push request.
- in_ready_o  output  1  FIFO not full.
- in_a_i  input  8  operand a.
- in_b_i  input  8  operand b (a perfect cube is expected by accel).
- acc_start_o  output  1  start pulse to accel start_i.
- acc_a_o  output  8  to accel a_in.
- acc_b_o  output  8  to accel b_in.
- acc_busy_i  input  1  from accel busy_out.
- acc_y_i  input  16  from accel y_out.
- res_valid_o  output  1  result slot full.
- res_ready_i  input  1  consumer accepts result.
- res_y_o  output  16  captured result.
- done_cnt_o  output  16  completed-operation count; wraps at 16'hFFFF to 0.
- err_o  output  1  sticky watchdog error.

Behaviour:
- Reset (rst_i=1 at a rising edge) clears the following; this applies mid-operation too. The accel shares rst_i.
  - FIFO emptied, pointers to 0.
  - FSM to IDLE.
  - Outputs: acc_start_o=0, acc_a_o=0, acc_b_o=0, res_valid_o=0, res_y_o=0, done_cnt_o=0, err_o=0.
  - in_ready_o=1 from the first cycle after reset.
- FIFO:
  - Push occurs when in_valid_i && in_ready_o. in_ready_o = !full, with no bypass.
  - A push when full is ignored and the data is lost to the block; the producer must hold valid.
  - A pushed entry is visible to the FSM on the next cycle.
  - Simultaneous push and pop are allowed at any non-full occupancy; occupancy is unchanged.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE: if FIFO not empty and res_valid_o=0:
    - pop the head;
    - register the head into acc_a_o/acc_b_o;
    - go to ISSUE.
    - Otherwise stay.
  - ISSUE: acc_start_o=1 for exactly this one cycle (registered). acc_a_o/acc_b_o stay stable until the next ISSUE. Go to WAIT_HI.
  - WAIT_HI: wait for acc_busy_i=1, then go to WAIT_LO.
  - WAIT_LO: on the first cycle with acc_busy_i=0:
    - res_y_o <= acc_y_i;
    - res_valid_o <= 1;
    - done_cnt_o <= done_cnt_o + 1;
    - go to IDLE.
- Result slot:
  - res_valid_o clears on the cycle after res_valid_o && res_ready_i.
  - While the slot is full, no new start is issued (backpressure).
  - An accept and a new capture cannot coincide, because capture only follows an issue, and an issue requires an empty slot.
- Minimum spacing between start pulses is 4 clocks plus the accel busy time.
- Latency: push at cycle N gives ISSUE at N+2 at the earliest, when the FIFO was empty and the slot free.
- Without the watchdog, a missing busy rise stalls the FSM in WAIT_HI forever. err_o is then tied to 0.

Optional Feature:
- Macro ACC_FEEDER_WDOG_EN.
- Defined:
  - A counter clears on entry to WAIT_HI and increments each cycle in WAIT_HI or WAIT_LO.
  - When the count reaches WDOG_CYCLES, the operation is aborted:
    - res_y_o <= 16'hFFFF;
    - res_valid_o <= 1;
    - err_o <= 1, sticky until reset;
    - done_cnt_o is not incremented;
    - FSM goes to IDLE.
  - A busy fall on the same cycle as the timeout wins, giving a normal capture.
- Undefined: no counter logic, err_o constant 0, WDOG_CYCLES unused.

Test Plan:
- Single op, with the real accel instance: push a=5, b=27 while the slot is free -> one acc_start_o pulse; then res_valid_o=1 with res_y_o=21 and done_cnt_o=1.
- Burst with backpressure:
  - Push (14,64), (0,0), (3,8), (7,125), (1,1) while res_ready_i=0.
  - in_ready_o drops after DEPTH=4 pending entries.
  - No second start until the first result is accepted.
  - Then accept all, in order, expecting res_y_o = 50, 0, 13, 31, 5.
- Simultaneous push and pop: FIFO at 2 entries, push on the same cycle as the IDLE pop -> occupancy stays 2, no entry lost or duplicated, order preserved.
- Reset mid-operation: assert rst_i in WAIT_LO with 3 entries queued -> next cycle all outputs are at their reset values, and no stale result appears after deassertion.
- Watchdog, with ACC_FEEDER_WDOG_EN and a stub busy held at 0, WDOG_CYCLES=8 -> 8 cycles after ISSUE, res_y_o=16'hFFFF, res_valid_o=1, err_o=1, done_cnt_o unchanged. Without the macro, the FSM stays in WAIT_HI.
- Counter wrap: preload via 65536 stubbed ops, or force done_cnt_o=16'hFFFF -> the next completion yields 0.
